// File: rtl/l15_pkg.sv
// L1.5 responder model: shared request/response encodings,
// store byte-lane decode and response-type decode.
package l15_pkg;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] IMISS_RQ = 5'b10000;
  localparam logic [4:0] STORE_RQ = 5'b00001;

  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] INT_RET   = 4'b0111;
  localparam logic [3:0] ERR_RET   = 4'b1100;

  localparam logic [2:0] SZ_1B = 3'd0;
  localparam logic [2:0] SZ_2B = 3'd1;
  localparam logic [2:0] SZ_4B = 3'd2;
  localparam logic [2:0] SZ_8B = 3'd3;

  typedef enum logic [2:0] {
    ST_WAKE,
    ST_INT,
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  // Bit k enables doubleword byte k; zero means misaligned or bad size.
  function automatic logic [7:0] store_be(
    input logic [2:0] size,
    input logic [2:0] off
  );
    logic [7:0] be;
    be = '0;
    unique case (1'b1)
      (size == SZ_1B): be = 8'h01 << off;
      (size == SZ_2B): be = off[0] ? 8'h00 : 8'h03 << off;
      (size == SZ_4B): be = (off[1:0] != 2'd0) ? 8'h00 : 8'h0F << off;
      (size == SZ_8B): be = (off != 3'd0) ? 8'h00 : 8'hFF;
      default:         be = 8'h00;
    endcase
    return be;
  endfunction

  function automatic logic [3:0] ret_of(
    input logic [4:0] rq,
    input logic [7:0] be,
    input logic       win
  );
    logic [3:0] rt;
    rt = ERR_RET;
    if (win) begin
      unique case (rq)
        LOAD_RQ:  rt = LOAD_RET;
        IMISS_RQ: rt = IFILL_RET;
        STORE_RQ: rt = (be != 8'h00) ? ST_ACK : ERR_RET;
        default:  rt = ERR_RET;
      endcase
    end
    return rt;
  endfunction

endpackage

// File: rtl/l15_resp_mem.sv
// Word RAM for the L1.5 model: doubleword write with 8 byte lanes,
// 16-byte line read. Words hold wire byte order, byte 0 in [31:24].
module l15_resp_mem #(
  parameter int WORDS = 4096
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [$clog2(WORDS)-2:0]   dw_i,
  input  logic [7:0]                 be_i,
  input  logic [63:0]                wdata_i,
  input  logic [$clog2(WORDS)-3:0]   line_i,
  output logic [127:0]               line_o
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < 8; k++) begin
        if (be_i[k]) begin
          mem_q[{dw_i, k[2]}][8*(3-(k%4)) +: 8] <= wdata_i[8*(7-k) +: 8];
        end
      end
    end
  end

  assign line_o = {mem_q[{line_i, 2'd0}], mem_q[{line_i, 2'd1}],
                   mem_q[{line_i, 2'd2}], mem_q[{line_i, 2'd3}]};

endmodule

// File: rtl/l15_resp_model.sv
// Stand-in L1.5 responder: services ifill/load/store from local RAM
// and raises the start-up wake-up interrupt after reset.
module l15_resp_model
  import l15_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h40000000,
  parameter int          MEM_WORDS    = 4096,
  parameter int          LATENCY      = 2,
  parameter int          WAKEUP_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transducer_l15_val,
  input  logic [4:0]  transducer_l15_rqtype,
  input  logic [2:0]  transducer_l15_size,
  input  logic [31:0] transducer_l15_address,
  input  logic [63:0] transducer_l15_data,
  output logic        l15_transducer_header_ack,
  output logic        l15_transducer_ack,
  output logic        l15_transducer_val,
  output logic [3:0]  l15_transducer_returntype,
  output logic [63:0] l15_transducer_data_0,
  output logic [63:0] l15_transducer_data_1,
  input  logic        transducer_l15_req_ack,
  input  logic        bd_we,
  input  logic [31:0] bd_addr,
  input  logic [31:0] bd_wdata
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [15:0] WAKE_LAST =
    (WAKEUP_DELAY > 0) ? 16'(WAKEUP_DELAY - 1) : 16'd0;
  // Preloaded one short so val rises exactly LATENCY cycles after accept.
  localparam logic [15:0] LAT_PRE   = 16'(LATENCY - 1);
  localparam bit          DIRECT    = (LATENCY <= 1);

  state_e        state_q;
  logic [15:0]   cnt_q;
  logic [4:0]    rq_q;
  logic [2:0]    size_q;
  logic [31:0]   addr_q;
  logic          val_q;
  logic [3:0]    rt_q;
  logic [63:0]   d0_q, d1_q;

  logic          idle, accept;
  logic [4:0]    r_rq;
  logic [2:0]    r_size;
  logic [31:0]   r_addr, r_off, bd_off;
  logic          r_win, bd_ok;
  logic [7:0]    r_be;
  logic [3:0]    r_ret;
  logic [127:0]  line, resp_line;
  logic          we;
  logic [AW-2:0] w_dw;
  logic [7:0]    w_be;
  logic [63:0]   w_data;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle && transducer_l15_val && !rst;

  assign l15_transducer_header_ack = accept;
  assign l15_transducer_ack        = accept;

  always_comb begin
    r_rq      = idle ? transducer_l15_rqtype  : rq_q;
    r_size    = idle ? transducer_l15_size    : size_q;
    r_addr    = idle ? transducer_l15_address : addr_q;
    r_off     = r_addr - BASE_ADDR;
    r_win     = r_off < WIN_BYTES;
    r_be      = store_be(r_size, r_addr[2:0]);
    r_ret     = ret_of(r_rq, r_be, r_win);
    resp_line = '0;
    if (r_ret == LOAD_RET || r_ret == IFILL_RET) resp_line = line;
  end

  always_comb begin
    bd_off = bd_addr - BASE_ADDR;
    bd_ok  = bd_we && (rst || state_q == ST_WAKE) && (bd_off < WIN_BYTES);
    we     = 1'b0;
    w_dw   = r_off[AW+1:3];
    w_be   = r_be;
    w_data = transducer_l15_data;
    if (bd_ok) begin
      we     = 1'b1;
      w_dw   = bd_off[AW+1:3];
      w_be   = bd_off[2] ? 8'hF0 : 8'h0F;
      w_data = {bd_wdata, bd_wdata};
    end else if (accept && r_ret == ST_ACK) begin
      we = 1'b1;
    end
  end

  l15_resp_mem #(
    .WORDS (MEM_WORDS)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .dw_i    (w_dw),
    .be_i    (w_be),
    .wdata_i (w_data),
    .line_i  (r_off[AW+1:4]),
    .line_o  (line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAKE;
      cnt_q   <= '0;
      rq_q    <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      val_q   <= 1'b0;
      rt_q    <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      unique case (state_q)
        ST_WAKE: begin
          if (cnt_q >= WAKE_LAST) begin
            state_q <= ST_INT;
            val_q   <= 1'b1;
            rt_q    <= INT_RET;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_INT: begin
          if (transducer_l15_req_ack) begin
            state_q <= ST_IDLE;
            val_q   <= 1'b0;
            rt_q    <= '0;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            rq_q   <= transducer_l15_rqtype;
            size_q <= transducer_l15_size;
            addr_q <= transducer_l15_address;
            if (DIRECT) begin
              state_q <= ST_RESP;
              val_q   <= 1'b1;
              rt_q    <= r_ret;
              {d0_q, d1_q} <= resp_line;
            end else begin
              cnt_q   <= LAT_PRE;
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_q == 16'd1) begin
            state_q <= ST_RESP;
            val_q   <= 1'b1;
            rt_q    <= r_ret;
            {d0_q, d1_q} <= resp_line;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_RESP: begin
          if (transducer_l15_req_ack) begin
            state_q <= ST_IDLE;
            val_q   <= 1'b0;
            rt_q    <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
          end
        end
        default: state_q <= ST_WAKE;
      endcase
    end
  end

  assign l15_transducer_val        = val_q && !rst;
  assign l15_transducer_returntype = rst ? 4'd0  : rt_q;
  assign l15_transducer_data_0     = rst ? 64'd0 : d0_q;
  assign l15_transducer_data_1     = rst ? 64'd0 : d1_q;

endmodule
